// File: rtl/sync_multi_pkg.sv
// sync_multi_pkg
//   Shared definitions for the sync_multi probe-input conditioner:
//   mode encodings and a constant-foldable ceiling-log2 helper used to size
//   the debounce and flush counters.
package sync_multi_pkg;

   localparam logic [1:0] MODE_RISE  = 2'd0;
   localparam logic [1:0] MODE_FALL  = 2'd1;
   localparam logic [1:0] MODE_FILT  = 2'd2;
   localparam logic [1:0] MODE_DEMUX = 2'd3;

   // Bits needed to hold values 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_multi_filt_bit.sv
// sync_multi_filt_bit
//   One bit of the debounce filter. A new level is accepted into held only
//   after the rising- and falling-edge samples agree with each other and
//   differ from held for len consecutive cycles.
// Ports:
//   clock    sample clock (posedge)
//   reset_n  asynchronous active-low reset
//   rise     posedge sample of this bit
//   fall     negedge sample of this bit
//   len      effective filter length (already forced to >= 1 by the parent)
//   reload   configuration change: zero the counter, load held from rise
//   held     accepted (debounced) level
module sync_multi_filt_bit #(
   parameter int CW = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          rise,
   input  logic          fall,
   input  logic [CW-1:0] len,
   input  logic          reload,
   output logic          held
);

   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_inc;
   logic          agree;

   // One extra bit on the increment so the compare can never wrap.
   assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
   assign agree   = (rise == fall) && (rise != held);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         held <= 1'b0;
         cnt  <= '0;
      end else if (reload) begin
         held <= rise;
         cnt  <= '0;
      end else if (agree) begin
         if (cnt_inc >= {1'b0, len}) begin
            held <= rise;
            cnt  <= '0;
         end else begin
            cnt <= cnt_inc[CW-1:0];
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/sync_multi.sv
// sync_multi
//   Logic-analyzer probe input conditioner. Samples data_in on both clock
//   edges and emits a registered word in one of four modes: raw posedge
//   sample, raw negedge sample, per-bit debounce filter, or 2x demux
//   (low half from the posedge sample, high half from the preceding
//   negedge sample). data_valid stays low for FLUSH_CYCLES cycles after
//   reset release or any change of mode/filt_len.
// Ports:
//   clock       sample clock
//   reset_n     asynchronous active-low reset
//   data_in     raw probe bus (WIDTH)
//   mode        0 rise, 1 fall, 2 filter, 3 demux
//   filt_len    debounce length (CW bits), 0 behaves as 1
//   data_out    conditioned sample (WIDTH)
//   data_valid  data_out was produced entirely under the current config
// Build option:
//   SYNC_MULTI_META2_EN  adds a second capture flop on each edge path
//                        (two-flop synchroniser, raw/demux latency 3).
module sync_multi
   import sync_multi_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int FILT_MAX     = 15,
   parameter int FLUSH_CYCLES = 3,
   parameter int CW           = clog2(FILT_MAX + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       mode,
   input  logic [CW-1:0]    filt_len,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid
);

   localparam int HALF = WIDTH / 2;
   localparam int FW   = clog2(FLUSH_CYCLES + 1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

   logic [WIDTH-1:0] s_r;
   logic [WIDTH-1:0] s_f;
   logic [WIDTH-1:0] smp_r;
   logic [WIDTH-1:0] smp_f;
   logic [WIDTH-1:0] held;
   logic [WIDTH-1:0] out_next;
   logic [1:0]       mode_q;
   logic [CW-1:0]    len_q;
   logic [CW-1:0]    len_eff;
   logic [FW-1:0]    flush;
   logic             init_q;
   logic             cfg_change;
   logic             reload;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s_r <= '0;
      end else begin
         s_r <= data_in;
      end
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s_f <= '0;
      end else begin
         s_f <= data_in;
      end
   end

`ifdef SYNC_MULTI_META2_EN
   logic [WIDTH-1:0] s_r2;
   logic [WIDTH-1:0] s_f2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s_r2 <= '0;
      end else begin
         s_r2 <= s_r;
      end
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s_f2 <= '0;
      end else begin
         s_f2 <= s_f;
      end
   end

   assign smp_r = s_r2;
   assign smp_f = s_f2;
`else
   assign smp_r = s_r;
   assign smp_f = s_f;
`endif

   // Reset release is handled exactly like a configuration change so the
   // filter and flush counter start from a known reload point.
   assign cfg_change = (mode != mode_q) || (filt_len != len_q);
   assign reload     = cfg_change || !init_q;
   assign len_eff    = (len_q == '0) ? {{(CW-1){1'b0}}, 1'b1} : len_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= MODE_RISE;
         len_q  <= '0;
         init_q <= 1'b0;
         flush  <= '0;
      end else begin
         mode_q <= mode;
         len_q  <= filt_len;
         init_q <= 1'b1;
         if (reload) begin
            flush <= FLUSH_LOAD;
         end else if (flush != '0) begin
            flush <= flush - FW'(1);
         end
      end
   end

   assign data_valid = init_q && (flush == '0);

   for (genvar i = 0; i < WIDTH; i++) begin : g_filt
      sync_multi_filt_bit #(
         .CW (CW)
      ) u_bit (
         .clock   (clock),
         .reset_n (reset_n),
         .rise    (smp_r[i]),
         .fall    (smp_f[i]),
         .len     (len_eff),
         .reload  (reload),
         .held    (held[i])
      );
   end

   always_comb begin
      out_next = smp_r;
      case (mode_q)
         MODE_RISE:  out_next = smp_r;
         MODE_FALL:  out_next = smp_f;
         MODE_FILT:  out_next = held;
         MODE_DEMUX: out_next = {smp_f[HALF-1:0], smp_r[HALF-1:0]};
         default:    out_next = smp_r;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
      end else begin
         data_out <= out_next;
      end
   end

endmodule

// File: tb/tb_sync_multi.sv
// tb_sync_multi
//   Directed bench for sync_multi. A pin-level model tracks what each
//   posedge must produce from the values seen on data_in at each edge and
//   is compared on every negedge; literal expectations pin the model.
module tb_sync_multi;

   localparam int WIDTH = 32;
   localparam int FLUSH = 3;
`ifdef SYNC_MULTI_META2_EN
   localparam int D = 2;
`else
   localparam int D = 1;
`endif

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic [1:0]       mode = 2'd0;
   logic [3:0]       filt_len = 4'd0;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // model state
   logic [WIDTH-1:0] a1, a2, b1, b2;
   logic [WIDTH-1:0] held_m;
   logic [WIDTH-1:0] exp_out;
   logic             exp_valid;
   logic [1:0]       mode_p;
   logic [3:0]       len_p;
   int               since;
   bit               first;
   int               run [WIDTH];

   sync_multi #(
      .WIDTH        (WIDTH),
      .FILT_MAX     (15),
      .FLUSH_CYCLES (FLUSH)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .data_in    (data_in),
      .mode       (mode),
      .filt_len   (filt_len),
      .data_out   (data_out),
      .data_valid (data_valid)
   );

   always #5 clock = ~clock;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
      end
   endtask

   task model_clear();
      a1 = '0; a2 = '0; b1 = '0; b2 = '0;
      held_m = '0; exp_out = '0; exp_valid = 1'b0;
      mode_p = 2'd0; len_p = 4'd0; since = 0; first = 1'b1;
      for (int i = 0; i < WIDTH; i++) run[i] = 0;
   endtask

   // What one posedge must do, stated from the pin history.
   task model_posedge();
      logic [WIDTH-1:0] r, f;
      bit reconf;
      int len_use;
      r = (D == 2) ? a2 : a1;
      f = (D == 2) ? b2 : b1;
      reconf = first || (mode != mode_p) || (filt_len != len_p);
      case (mode_p)
         2'd0:    exp_out = r;
         2'd1:    exp_out = f;
         2'd2:    exp_out = held_m;
         default: exp_out = {f[15:0], r[15:0]};
      endcase
      len_use = (len_p == 4'd0) ? 1 : int'(len_p);
      if (reconf) begin
         held_m = r;
         for (int i = 0; i < WIDTH; i++) run[i] = 0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r[i] == f[i] && r[i] != held_m[i]) begin
               run[i]++;
               if (run[i] >= len_use) begin
                  held_m[i] = r[i];
                  run[i] = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
      end
      if (reconf) since = 0;
      else if (since < 1000) since++;
      exp_valid = (since >= FLUSH);
      first = 1'b0;
      mode_p = mode;
      len_p = filt_len;
      a2 = a1;
      a1 = data_in;
   endtask

   task model_proc();
      forever begin
         @(posedge clock or negedge clock or negedge reset_n);
         if (!reset_n) begin
            model_clear();
         end else if (clock) begin
            model_posedge();
         end else begin
            if (cmp_en) begin
               check32("model_out", data_out, exp_out);
               check32("model_valid", 32'(data_valid), 32'(exp_valid));
            end
            b2 = b1;
            b1 = data_in;
         end
      end
   endtask

   // One cycle: a is present at the posedge, b at the following negedge.
   task cyc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m, input logic [3:0] l);
      data_in = a;
      mode = m;
      filt_len = l;
      @(posedge clock);
      #1;
      data_in = b;
      @(negedge clock);
      #1;
   endtask

   initial begin
      fork
         model_proc();
      join_none

      reset_n = 1'b0;
      data_in = 32'hA5A5_A5A5;
      mode = 2'd0;
      filt_len = 4'd0;
      repeat (3) @(negedge clock);
      #1;
      cmp_en = 1'b1;
      check32("reset_out", data_out, 32'h0);
      check32("reset_valid", 32'(data_valid), 32'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'd0, 4'd0);
         check32("release_valid", 32'(data_valid), (i == 3) ? 32'h1 : 32'h0);
      end
      check32("rise_out", data_out, 32'hA5A5_A5A5);

      repeat (6) cyc(32'h0000_1234, 32'h0000_ABCD, 2'd3, 4'd0);
      check32("demux_out", data_out, 32'hABCD_1234);
      check32("demux_valid", 32'(data_valid), 32'h1);

      repeat (10) cyc(32'h0, 32'h0, 2'd2, 4'd4);
      check32("filt_base", data_out, 32'h0);
      repeat (3) cyc(32'h1, 32'h1, 2'd2, 4'd4);
      for (int i = 0; i < 6; i++) begin
         cyc(32'h0, 32'h0, 2'd2, 4'd4);
         check32("filt_glitch3", data_out, 32'h0);
      end
      repeat (4) cyc(32'h1, 32'h1, 2'd2, 4'd4);
      repeat (3) cyc(32'h0, 32'h1, 2'd2, 4'd4);
      check32("filt_pulse4", data_out, 32'h1);
      repeat (8) cyc(32'h0, 32'h0, 2'd2, 4'd4);
      check32("filt_back0", data_out, 32'h0);

      repeat (6) cyc(32'h2, 32'h0, 2'd2, 4'd0);
      check32("len0_halfglitch", data_out, 32'h0);
      cyc(32'h2, 32'h2, 2'd2, 4'd0);
      repeat (3) cyc(32'h2, 32'h0, 2'd2, 4'd0);
      check32("len0_accept", data_out, 32'h2);

      repeat (6) cyc(32'h1111_1111, 32'h2222_2222, 2'd0, 4'd0);
      check32("rise_out2", data_out, 32'h1111_1111);
      for (int i = 0; i < 4; i++) begin
         cyc(32'h1111_1111, 32'h2222_2222, 2'd1, 4'd0);
         check32("fall_flush", 32'(data_valid), (i == 3) ? 32'h1 : 32'h0);
      end
      check32("fall_out", data_out, 32'h2222_2222);

      for (int i = 0; i < 4; i++) begin
         cyc(32'h1111_1111, 32'h2222_2222, 2'd2, 4'd5);
         check32("dual_change_flush", 32'(data_valid), (i == 3) ? 32'h1 : 32'h0);
      end

      repeat (6) cyc(32'h0000_1234, 32'h0000_ABCD, 2'd3, 4'd5);
      check32("demux_out2", data_out, 32'hABCD_1234);
      data_in = 32'h0000_1234;
      @(posedge clock);
      #1;
      data_in = 32'h0000_ABCD;
      reset_n = 1'b0;
      #1;
      check32("midreset_out", data_out, 32'h0);
      check32("midreset_valid", 32'(data_valid), 32'h0);
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(32'h0000_1234, 32'h0000_ABCD, 2'd3, 4'd5);
         check32("recover_valid", 32'(data_valid), (i == 3) ? 32'h1 : 32'h0);
      end
      check32("recover_out", data_out, 32'hABCD_1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
